// File: rtl/ram_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter_if
//  Purpose  : Bundles the per-core request/response channels, the shared RAM
//             port and the grant debug view of ram_arbiter.
//  Ports    : iREN/iaddr/iwait/iload  - per-core instruction fetch channel
//             dREN/dWEN/daddr/dstore/dwait/dload - per-core data channel
//             ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate - RAM port
//             gnt_valid/gnt_cpu/gnt_data - current grant (debug)
//  Modports : master - cores and RAM model side
//             slave  - arbiter side
//  Revision : 1.0 - initial release
// ============================================================================
interface ram_arbiter_if #(
   parameter int CPUS   = 2,
   parameter int WORD_W = 32,
   parameter int ADDR_W = 32
);
   localparam int c_cpu_w = (CPUS > 1) ? $clog2(CPUS) : 1;

   // core side
   logic [CPUS-1:0]        iREN;
   logic [CPUS*ADDR_W-1:0] iaddr;
   logic [CPUS-1:0]        iwait;
   logic [CPUS*WORD_W-1:0] iload;
   logic [CPUS-1:0]        dREN;
   logic [CPUS-1:0]        dWEN;
   logic [CPUS*ADDR_W-1:0] daddr;
   logic [CPUS*WORD_W-1:0] dstore;
   logic [CPUS-1:0]        dwait;
   logic [CPUS*WORD_W-1:0] dload;

   // RAM side
   logic                   ramREN;
   logic                   ramWEN;
   logic [ADDR_W-1:0]      ramaddr;
   logic [WORD_W-1:0]      ramstore;
   logic [WORD_W-1:0]      ramload;
   logic [1:0]             ramstate;

   // grant debug view
   logic                   gnt_valid;
   logic [c_cpu_w-1:0]     gnt_cpu;
   logic                   gnt_data;

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload,
      input  ramREN, ramWEN, ramaddr, ramstore,
      input  gnt_valid, gnt_cpu, gnt_data
   );

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload,
      output ramREN, ramWEN, ramaddr, ramstore,
      output gnt_valid, gnt_cpu, gnt_data
   );
endinterface
`default_nettype wire

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_arbiter
//  Purpose  : Shares one RAM port among CPUS cores, each with an instruction
//             and a data channel. Data beats instructions, round-robin within
//             each class, instruction starvation bounded by STARVE_LIMIT, and
//             the grant is registered and held for the whole RAM transaction.
//  Ports    : CLK  - clock, rising edge
//             nRST - synchronous reset, active high
//             bus  - ram_arbiter_if.slave (core channels, RAM port, grant view)
//  Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
   parameter int CPUS         = 2,
   parameter int WORD_W       = 32,
   parameter int ADDR_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          CLK,
   input  logic          nRST,
   ram_arbiter_if.slave  bus
);

   localparam int c_cpu_w = (CPUS > 1) ? $clog2(CPUS) : 1;
   // A zero limit still needs a 1-bit counter; it simply never moves.
   localparam int c_cnt_w = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   localparam logic [1:0]         c_ram_access = 2'd2;
   localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t               state_q,   state_d;
   logic [c_cpu_w-1:0]   owner_q,   owner_d;
   logic                 is_data_q, is_data_d;
   logic                 write_q,   write_d;
   logic [c_cpu_w-1:0]   dptr_q,    dptr_d;
   logic [c_cpu_w-1:0]   iptr_q,    iptr_d;
   logic [c_cnt_w-1:0]   starve_q,  starve_d;

   // First requester at or after ptr, searching upward modulo CPUS. The loop
   // runs from the farthest offset down so the nearest one is kept last.
   function automatic logic [c_cpu_w-1:0] rr_pick(
      input logic [CPUS-1:0]    req,
      input logic [c_cpu_w-1:0] ptr
   );
      logic [c_cpu_w-1:0] win;
      int                 idx;
      win = ptr;
      for (int k = CPUS - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= CPUS) idx = idx - CPUS;
         if (req[idx]) win = c_cpu_w'(idx);
      end
      return win;
   endfunction

   function automatic logic [c_cpu_w-1:0] next_idx(input logic [c_cpu_w-1:0] cur);
      int idx;
      idx = int'(cur) + 1;
      if (idx >= CPUS) idx = 0;
      return c_cpu_w'(idx);
   endfunction

   logic [CPUS-1:0]    w_dreq;
   logic               w_any_d;
   logic               w_any_i;
   logic               w_starved;
   logic [c_cpu_w-1:0] w_dwin;
   logic [c_cpu_w-1:0] w_iwin;
   logic               w_owner_req;
   logic               w_access;
   logic               w_grant;

   assign w_dreq   = bus.dREN | bus.dWEN;
   assign w_any_d  = |w_dreq;
   assign w_any_i  = |bus.iREN;
   assign w_dwin   = rr_pick(w_dreq,   dptr_q);
   assign w_iwin   = rr_pick(bus.iREN, iptr_q);
   assign w_access = (bus.ramstate == c_ram_access);
   assign w_starved = (STARVE_LIMIT > 0) && (starve_q == c_starve_max) && w_any_i;
   assign w_owner_req = is_data_q ? w_dreq[owner_q] : bus.iREN[owner_q];

   // Reset masks the grant immediately so outputs read idle in the reset
   // cycle itself, not just after the edge.
   assign w_grant = (state_q == S_GRANT) && !nRST;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (nRST) begin
         state_q   <= S_IDLE;
         owner_q   <= '0;
         is_data_q <= 1'b0;
         write_q   <= 1'b0;
         dptr_q    <= '0;
         iptr_q    <= '0;
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         is_data_q <= is_data_d;
         write_q   <= write_d;
         dptr_q    <= dptr_d;
         iptr_q    <= iptr_d;
         starve_q  <= starve_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      is_data_d = is_data_q;
      write_d   = write_q;
      dptr_d    = dptr_q;
      iptr_d    = iptr_q;
      starve_d  = starve_q;

      case (state_q)
         S_IDLE: begin
            if (w_any_d || w_any_i) begin
               state_d = S_GRANT;
               if (!w_starved && w_any_d) begin
                  owner_d   = w_dwin;
                  is_data_d = 1'b1;
                  // a simultaneous read+write is treated as a write
                  write_d   = bus.dWEN[w_dwin];
               end else begin
                  owner_d   = w_iwin;
                  is_data_d = 1'b0;
                  write_d   = 1'b0;
               end
            end
         end

         S_GRANT: begin
            if (w_access) begin
               state_d = S_IDLE;
               if (is_data_q) begin
                  dptr_d = next_idx(owner_q);
                  if (w_any_i) begin
                     if (starve_q != c_starve_max) starve_d = starve_q + 1'b1;
                  end else begin
                     starve_d = '0;
                  end
               end else begin
                  iptr_d   = next_idx(owner_q);
                  starve_d = '0;
               end
            end else if (!w_owner_req) begin
               // abandoned grant: no pointer or counter bookkeeping
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // RAM port and grant view
   // ------------------------------------------------------------------
   always_comb begin
      bus.ramREN    = 1'b0;
      bus.ramWEN    = 1'b0;
      bus.ramaddr   = '0;
      bus.ramstore  = '0;
      bus.gnt_valid = 1'b0;
      bus.gnt_cpu   = '0;
      bus.gnt_data  = 1'b0;
      if (w_grant) begin
         bus.ramREN    = !write_q;
         bus.ramWEN    = write_q;
         bus.ramaddr   = is_data_q ? bus.daddr[int'(owner_q)*ADDR_W +: ADDR_W]
                                   : bus.iaddr[int'(owner_q)*ADDR_W +: ADDR_W];
         if (write_q) bus.ramstore = bus.dstore[int'(owner_q)*WORD_W +: WORD_W];
         bus.gnt_valid = 1'b1;
         bus.gnt_cpu   = owner_q;
         bus.gnt_data  = is_data_q;
      end
   end

   // ------------------------------------------------------------------
   // Per-core responses: only the owner sees ramload and a wait release
   // ------------------------------------------------------------------
   always_comb begin
      bus.iwait = '1;
      bus.dwait = '1;
      bus.iload = '0;
      bus.dload = '0;
      for (int k = 0; k < CPUS; k++) begin
         if (w_grant && (owner_q == c_cpu_w'(k))) begin
            if (is_data_q) begin
               bus.dload[k*WORD_W +: WORD_W] = bus.ramload;
               bus.dwait[k] = !w_access;
            end else begin
               bus.iload[k*WORD_W +: WORD_W] = bus.ramload;
               bus.iwait[k] = !w_access;
            end
         end
      end
   end

endmodule
`default_nettype wire
